// File: rtl/fpu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_req_arbiter
// Purpose  : Round-robin sharing of one FPU among NUM_REQ requesters with one
//            epoch-tagged operation in flight, flush support and a watchdog.
// Revision : 1.0
// ============================================================================
module fpu_req_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 256,
    parameter int WIDTH     = 64,
    parameter int TIMEOUT   = 255,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int TAG_W    = IDW + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
    input  logic [NUM_REQ-1:0]           req_flush_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    input  logic [NUM_REQ-1:0]           rsp_ready_i,
    output logic [WIDTH-1:0]             rsp_result_o,
    output logic [4:0]                   rsp_status_o,
    output logic                         fpu_valid_o,
    input  logic                         fpu_ready_i,
    output logic [PAYLOAD_W-1:0]         fpu_payload_o,
    output logic [TAG_W-1:0]             fpu_tag_o,
    output logic                         fpu_flush_o,
    input  logic                         fpu_out_valid_i,
    output logic                         fpu_out_ready_o,
    input  logic [WIDTH-1:0]             fpu_result_i,
    input  logic [4:0]                   fpu_status_i,
    input  logic [TAG_W-1:0]             fpu_tag_i,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int              WDW        = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_MAX     = WDW'(TIMEOUT);
    localparam logic [4:0]      ST_TIMEOUT = 5'b10000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           state_q,   state_d;
    logic [IDW-1:0]       last_q,    last_d;
    logic [IDW-1:0]       owner_q,   owner_d;
    logic [1:0]           epoch_q,   epoch_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [WDW-1:0]       wdog_q,    wdog_d;
    logic [WIDTH-1:0]     result_q,  result_d;
    logic [4:0]           status_q,  status_d;
    logic                 timeout_q, timeout_d;
    logic                 flush_q,   flush_d;

    logic                 gnt_found;
    logic [IDW-1:0]       gnt_idx;
    logic [IDW:0]         cand;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [WDW-1:0]       wdog_inc;
    logic                 own_flush;
    logic                 tag_match;

    // Search starts just after the last winner and wraps modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid_i[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    assign gnt_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
    assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign wdog_inc  = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WDW'(1);
    assign own_flush = req_flush_i[owner_q];
    assign tag_match = (fpu_tag_i == {epoch_q, owner_q});

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        epoch_d   = epoch_q;
        payload_d = payload_q;
        wdog_d    = wdog_q;
        result_d  = result_q;
        status_d  = status_q;
        timeout_d = timeout_q;
        flush_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    payload_d = req_payload_i[int'(gnt_idx)*PAYLOAD_W +: PAYLOAD_W];
                    owner_d   = gnt_idx;
                    last_d    = gnt_idx;
                    epoch_d   = epoch_q + 2'd1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (own_flush) begin
                    flush_d = 1'b1;
                    state_d = S_IDLE;
                end else if (fpu_ready_i) begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Flush beats both a matching result and a watchdog expiry.
                if (own_flush) begin
                    flush_d = 1'b1;
                    state_d = S_IDLE;
                end else if (fpu_out_valid_i && tag_match) begin
                    result_d = fpu_result_i;
                    status_d = fpu_status_i;
                    state_d  = S_RESP;
                end else if (wdog_inc == WD_MAX) begin
                    flush_d   = 1'b1;
                    result_d  = '0;
                    status_d  = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            S_RESP: begin
                if (own_flush || rsp_ready_i[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            last_q    <= IDW'(NUM_REQ - 1);
            owner_q   <= '0;
            epoch_q   <= '0;
            payload_q <= '0;
            wdog_q    <= '0;
            result_q  <= '0;
            status_q  <= '0;
            timeout_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            epoch_q   <= epoch_d;
            payload_q <= payload_d;
            wdog_q    <= wdog_d;
            result_q  <= result_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
            flush_q   <= flush_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE && gnt_found) ? gnt_oh : '0;
    assign rsp_valid_o     = (state_q == S_RESP) ? owner_oh : '0;
    assign rsp_result_o    = result_q;
    assign rsp_status_o    = status_q;
    assign fpu_valid_o     = (state_q == S_ISSUE);
    assign fpu_payload_o   = payload_q;
    assign fpu_tag_o       = {epoch_q, owner_q};
    assign fpu_flush_o     = flush_q;
    assign fpu_out_ready_o = 1'b1;
    assign busy_o          = (state_q != S_IDLE);
    assign timeout_o       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_req_arbiter
// Purpose  : Directed scoreboard bench for fpu_req_arbiter.
// Revision : 1.0
// ============================================================================
module tb_fpu_req_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int PAYLOAD_W = 256;
    localparam int WIDTH     = 64;
    localparam int TIMEOUT   = 12;
    localparam int TAG_W     = 3;

    localparam logic [PAYLOAD_W-1:0] PL0 = {8{32'hC0DE_0000}};
    localparam logic [PAYLOAD_W-1:0] PL1 = {8{32'h1234_5678}};

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b1;
    logic [NUM_REQ-1:0]           req_valid_i = '0;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i = '0;
    logic [NUM_REQ-1:0]           req_flush_i = '0;
    logic [NUM_REQ-1:0]           rsp_valid_o;
    logic [NUM_REQ-1:0]           rsp_ready_i = 2'b11;
    logic [WIDTH-1:0]             rsp_result_o;
    logic [4:0]                   rsp_status_o;
    logic                         fpu_valid_o;
    logic                         fpu_ready_i = 1'b1;
    logic [PAYLOAD_W-1:0]         fpu_payload_o;
    logic [TAG_W-1:0]             fpu_tag_o;
    logic                         fpu_flush_o;
    logic                         fpu_out_valid_i = 1'b0;
    logic                         fpu_out_ready_o;
    logic [WIDTH-1:0]             fpu_result_i = '0;
    logic [4:0]                   fpu_status_i = '0;
    logic [TAG_W-1:0]             fpu_tag_i = '0;
    logic                         busy_o;
    logic                         timeout_o;

    fpu_req_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PAYLOAD_W (PAYLOAD_W),
        .WIDTH     (WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_payload_i   (req_payload_i),
        .req_flush_i     (req_flush_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_result_o    (rsp_result_o),
        .rsp_status_o    (rsp_status_o),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready_i),
        .fpu_payload_o   (fpu_payload_o),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_flush_o     (fpu_flush_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .fpu_tag_i       (fpu_tag_i),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             owner;
        logic [WIDTH-1:0] res;
        logic [4:0]       st;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented response must equal the queue head.
    exp_t               m_e;
    logic [NUM_REQ-1:0] m_oh;
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o != '0) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 256'(rsp_valid_o), 256'(0));
            end else begin
                m_e  = sb_q[0];
                m_oh = 2'b01 << m_e.owner;
                check("rsp_data", {rsp_valid_o, rsp_status_o, rsp_result_o},
                      {m_oh, m_e.st, m_e.res});
                if ((rsp_valid_o & rsp_ready_i) != '0) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic push_exp(input logic owner, input logic [WIDTH-1:0] res, input logic [4:0] st);
        exp_t e;
        e.owner = owner;
        e.res   = res;
        e.st    = st;
        sb_q.push_back(e);
    endtask

    task automatic wait_issue(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (fpu_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 256'(ok), 256'(1));
    endtask

    task automatic fpu_ret(input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] res, input logic [4:0] st);
        fpu_out_valid_i = 1'b1;
        fpu_tag_i       = tag;
        fpu_result_i    = res;
        fpu_status_i    = st;
        step();
        fpu_out_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired, expected completion");
        $fatal(1);
    end

    initial begin
        logic             flag;
        int               cnt;
        int               n;
        logic [TAG_W-1:0] rr_tag [4];
        logic             rr_own [4];
        rr_tag = '{3'b010, 3'b101, 3'b110, 3'b001};
        rr_own = '{1'b0, 1'b1, 1'b0, 1'b1};
        req_payload_i = {PL1, PL0};

        // Reset state
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_out_ready", 256'(fpu_out_ready_o), 256'(1));
        check("rst_ctrl", {req_ready_o, rsp_valid_o, fpu_valid_o, fpu_flush_o, timeout_o, fpu_tag_o}, '0);
        check("rst_data", {rsp_result_o, rsp_status_o}, '0);
        check("rst_payload", fpu_payload_o, '0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single operation, result 10 cycles after accept
        step();
        req_valid_i = 2'b01;
        @(negedge clk_i);
        check("t1_grant", 256'(req_ready_o), 256'(2'b01));
        step();
        req_valid_i = 2'b00;
        @(negedge clk_i);
        check("t1_issue", {fpu_valid_o, busy_o, fpu_tag_o}, {1'b1, 1'b1, 3'b010});
        check("t1_payload", fpu_payload_o, PL0);
        flag = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk_i);
            flag &= busy_o;
        end
        step();
        push_exp(1'b0, 64'h3FF0_0000_0000_0000, 5'b00000);
        fpu_ret(3'b010, 64'h3FF0_0000_0000_0000, 5'b00000);
        @(negedge clk_i);
        flag &= busy_o;
        step();
        @(negedge clk_i);
        check("t1_busy_span", 256'(flag), 256'(1));
        check("t1_idle_after", 256'(busy_o), 256'(0));

        // Round-robin with both requesters valid
        do_reset();
        req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_issue($sformatf("t2_issue%0d", k));
            check($sformatf("t2_tag%0d", k), 256'(fpu_tag_o), 256'(rr_tag[k]));
            check($sformatf("t2_payload%0d", k), fpu_payload_o, rr_own[k] ? PL1 : PL0);
            step();
            push_exp(rr_own[k], 64'hABCD_0000_0000_0000 + 64'(k), 5'(k + 1));
            step();
            fpu_ret(rr_tag[k], 64'hABCD_0000_0000_0000 + 64'(k), 5'(k + 1));
        end
        req_valid_i = 2'b00;
        step();
        step();

        // Flush in WAIT and stale result from the killed operation
        do_reset();
        req_valid_i = 2'b01;
        wait_issue("t3_issue0");
        check("t3_tag0", 256'(fpu_tag_o), 256'(3'b010));
        req_valid_i = 2'b00;
        step();
        step();
        req_flush_i = 2'b01;
        cnt = 0;
        @(negedge clk_i);
        cnt += int'(fpu_flush_o);
        step();
        req_flush_i = 2'b00;
        @(negedge clk_i);
        cnt += int'(fpu_flush_o);
        check("t3_flush_to_idle", 256'(busy_o), 256'(0));
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk_i);
            cnt += int'(fpu_flush_o);
        end
        check("t3_flush_pulses", 256'(cnt), 256'(1));
        step();
        req_valid_i = 2'b10;
        wait_issue("t3_issue1");
        check("t3_tag1", 256'(fpu_tag_o), 256'(3'b101));
        req_valid_i = 2'b00;
        step();
        fpu_ret(3'b010, 64'hDEAD_BEEF_0000_0000, 5'b00001);
        @(negedge clk_i);
        check("t3_stale_dropped", {rsp_valid_o, busy_o}, {2'b00, 1'b1});
        step();
        push_exp(1'b1, 64'h4000_0000_0000_0000, 5'b00000);
        fpu_ret(3'b101, 64'h4000_0000_0000_0000, 5'b00000);
        step();
        step();

        // Watchdog expiry
        check("t4_timeout_pre", 256'(timeout_o), 256'(0));
        req_valid_i = 2'b01;
        wait_issue("t4_issue");
        check("t4_tag", 256'(fpu_tag_o), 256'(3'b110));
        req_valid_i = 2'b00;
        push_exp(1'b0, 64'h0, 5'b10000);
        n = 0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            n++;
            cnt += int'(fpu_flush_o);
            if (rsp_valid_o != '0) break;
        end
        check("t4_latency", 256'(n), 256'(TIMEOUT + 1));
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk_i);
            cnt += int'(fpu_flush_o);
        end
        check("t4_flush_pulses", 256'(cnt), 256'(1));
        check("t4_timeout_sticky", {timeout_o, busy_o}, {1'b1, 1'b0});

        // Response back-pressure with another requester pending
        step();
        rsp_ready_i = 2'b10;
        req_valid_i = 2'b01;
        wait_issue("t5_issue0");
        check("t5_tag0", 256'(fpu_tag_o), 256'(3'b000));
        req_valid_i = 2'b11;
        step();
        push_exp(1'b0, 64'h1111_2222_3333_4444, 5'b00100);
        fpu_ret(3'b000, 64'h1111_2222_3333_4444, 5'b00100);
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            flag &= (req_ready_o == 2'b00) && !fpu_valid_o && (rsp_valid_o == 2'b01);
            step();
        end
        check("t5_hold", 256'(flag), 256'(1));
        rsp_ready_i = 2'b11;
        step();
        @(negedge clk_i);
        check("t5_grant_after", 256'(req_ready_o), 256'(2'b10));
        wait_issue("t5_issue1");
        check("t5_tag1", 256'(fpu_tag_o), 256'(3'b011));
        req_valid_i = 2'b00;
        step();
        push_exp(1'b1, 64'h5555_6666_7777_8888, 5'b00010);
        fpu_ret(3'b011, 64'h5555_6666_7777_8888, 5'b00010);
        step();
        step();

        // Asynchronous reset while in WAIT
        req_valid_i = 2'b10;
        wait_issue("t6_issue");
        check("t6_tag", 256'(fpu_tag_o), 256'(3'b101));
        req_valid_i = 2'b00;
        step();
        #2 rst_ni = 1'b0;
        #1;
        check("t6_reset_ctrl", {busy_o, fpu_valid_o, timeout_o, rsp_valid_o, fpu_tag_o, fpu_flush_o}, '0);
        check("t6_reset_payload", fpu_payload_o, '0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        fpu_ret(3'b101, 64'h9999_0000_0000_0000, 5'b00000);
        flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            flag &= (rsp_valid_o == 2'b00) && !busy_o;
            step();
        end
        check("t6_no_response", 256'(flag), 256'(1));
        check("sb_drain", 256'(sb_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
